// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the SAR ADC conversion/readout engine.
package adc_spi_pkg;

  localparam int STREAM_WIDTH = 32;
  localparam int SYNC_DEPTH   = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT_BUSY,
    ST_READ,
    ST_OUT
  } state_t;

endpackage

// File: rtl/adc_spi_shifter.sv
// SCK generator and MSB-first shift register for one ADC readout.
// Bits are captured on the edge that ends each SCK high phase.
module adc_spi_shifter #(
  parameter int DATA_WIDTH = 18,
  parameter int SCK_HALF   = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  sdo,
  output logic                  sck,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data
);

  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam int BW = $clog2(DATA_WIDTH);

  logic          active;
  logic [HW-1:0] half_cnt;
  logic [BW-1:0] bit_cnt;
  logic          half_end;

  assign half_end = (half_cnt == HW'(SCK_HALF - 1));

  // Low half first, then high half; the falling edge samples sdo.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      active   <= 1'b0;
      half_cnt <= '0;
      bit_cnt  <= '0;
      sck      <= 1'b0;
      done     <= 1'b0;
      data     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        active   <= 1'b1;
        half_cnt <= '0;
        bit_cnt  <= '0;
        sck      <= 1'b0;
      end else if (active) begin
        if (half_end) begin
          half_cnt <= '0;
          sck      <= ~sck;
          if (sck) begin
            data <= {data[DATA_WIDTH-2:0], sdo};
            if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
              active <= 1'b0;
              done   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// Conversion-and-readout engine for a CNV/BUSY/SCK/SDO SAR ADC feeding an AXI4-Stream master.
// Optional: define ADC_SPI_READER_OVERRUN_CNT_EN to add the dropped-trigger counter overrun_count.
module adc_spi_reader
  import adc_spi_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int SCK_HALF     = 2,
  parameter int CNV_CYCLES   = 4,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    trigger,
  output logic                    cnv,
  input  logic                    busy,
  output logic                    sck,
  input  logic                    sdo,
  output logic [STREAM_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    timeout
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  ,
  output logic [15:0]             overrun_count
`endif
);

  localparam int CNT_MAX = (BUSY_TIMEOUT > CNV_CYCLES) ? BUSY_TIMEOUT : CNV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    cnv_n, tvalid_n, timeout_n;
  logic [STREAM_WIDTH-1:0] tdata_n;
  logic [SYNC_DEPTH-1:0]   busy_sync;
  logic                    busy_s;
  logic                    shift_start, shift_done;
  logic [DATA_WIDTH-1:0]   shift_data;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) busy_sync <= '0;
    else          busy_sync <= {busy_sync[SYNC_DEPTH-2:0], busy};
  end

  assign busy_s = busy_sync[SYNC_DEPTH-1];

  adc_spi_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .SCK_HALF   (SCK_HALF)
  ) u_shifter (
    .aclk    (aclk),
    .aresetn (aresetn),
    .start   (shift_start),
    .sdo     (sdo),
    .sck     (sck),
    .done    (shift_done),
    .data    (shift_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      cnv           <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      timeout       <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      cnv           <= cnv_n;
      m_axis_tvalid <= tvalid_n;
      m_axis_tdata  <= tdata_n;
      timeout       <= timeout_n;
    end
  end

  // One counter serves both the CNV pulse width and the BUSY wait.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cnv_n       = cnv;
    tvalid_n    = m_axis_tvalid;
    tdata_n     = m_axis_tdata;
    timeout_n   = timeout;
    shift_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (trigger) begin
          state_n = ST_CONV;
          cnv_n   = 1'b1;
          cnt_n   = '0;
        end
      end
      ST_CONV: begin
        if (cnt == CW'(CNV_CYCLES - 1)) begin
          state_n = ST_WAIT_BUSY;
          cnv_n   = 1'b0;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_WAIT_BUSY: begin
        if (!busy_s) begin
          state_n     = ST_READ;
          shift_start = 1'b1;
        end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
          state_n   = ST_IDLE;
          timeout_n = 1'b1;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      ST_READ: begin
        if (shift_done) begin
          state_n  = ST_OUT;
          tvalid_n = 1'b1;
          tdata_n  = STREAM_WIDTH'($signed(shift_data));
        end
      end
      ST_OUT: begin
        if (m_axis_tready) begin
          state_n  = ST_IDLE;
          tvalid_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)
      overrun_count <= '0;
    else if (trigger && (state != ST_IDLE) && (overrun_count != 16'hFFFF))
      overrun_count <= overrun_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_adc_spi_reader.sv
// Self-checking bench for adc_spi_reader: ADC model, timeline-based reference model, per-cycle compare.
module tb_adc_spi_reader;

  localparam int DW       = 18;
  localparam int SH       = 2;
  localparam int CNVC     = 4;
  localparam int TO       = 100;
  localparam int READ_LEN = 2 * SH * DW;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic        busy = 1'b0;
  logic        sdo = 1'b0;
  logic        m_axis_tready = 1'b0;
  logic        cnv, sck, m_axis_tvalid, timeout;
  logic [31:0] m_axis_tdata;
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
  logic [15:0] overrun_count;
`endif

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int hs_count = 0;

  always #5 aclk = ~aclk;

  adc_spi_reader #(
    .DATA_WIDTH   (DW),
    .SCK_HALF     (SH),
    .CNV_CYCLES   (CNVC),
    .BUSY_TIMEOUT (TO)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .trigger       (trigger),
    .cnv           (cnv),
    .busy          (busy),
    .sck           (sck),
    .sdo           (sdo),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .timeout       (timeout)
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
    ,
    .overrun_count (overrun_count)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] sext(input logic [DW-1:0] w);
    if (int'(w) >= (1 << (DW - 1))) return 32'(w) - 32'(1 << DW);
    return 32'(w);
  endfunction

  // ADC model: busy rises with cnv, falls busy_len cycles later; sdo advances on each sck fall.
  logic [DW-1:0] adc_word = '0;
  int            busy_len = 10;
  bit            busy_stuck = 1'b0;
  int            busy_left = 0;
  int            bit_idx = 0;
  logic          cnv_q = 1'b0;
  logic          sck_q = 1'b0;

  always @(posedge aclk) begin
    #1;
    if (cnv && !cnv_q) begin
      busy      = 1'b1;
      busy_left = busy_len;
      bit_idx   = DW - 1;
      sdo       = adc_word[DW-1];
    end else if (busy && !busy_stuck && busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy = 1'b0;
    end
    if (sck_q && !sck && bit_idx > 0) begin
      bit_idx--;
      sdo = adc_word[bit_idx];
    end
    cnv_q = cnv;
    sck_q = sck;
  end

  // Reference model: tracks each accepted conversion as a timeline of edge numbers.
  bit            in_use = 1'b0;
  int            t_acc = 0, t_read = -1, t_valid = -1;
  logic [DW-1:0] exp_word = '0;
  bit            exp_timeout = 1'b0;
  int            exp_ovr = 0;
  bit            h1 = 1'b0, h2 = 1'b0;
  bit            exp_cnv = 1'b0, exp_sck = 1'b0, exp_tvalid = 1'b0;

  always @(posedge aclk) begin : model
    bit bs;
    bit was_busy;
    int k;
    cyc++;
    if (!aresetn) begin
      in_use      = 1'b0;
      exp_timeout = 1'b0;
      exp_ovr     = 0;
      h1          = 1'b0;
      h2          = 1'b0;
    end else begin
      bs       = h2;
      h2       = h1;
      h1       = busy;
      was_busy = in_use;
      if (in_use && t_valid >= 0 && cyc > t_valid && m_axis_tready) begin
        in_use = 1'b0;
        hs_count++;
      end else if (in_use && t_read < 0 && cyc > t_acc + CNVC) begin
        if (!bs) begin
          t_read   = cyc;
          t_valid  = cyc + READ_LEN + 1;
          exp_word = adc_word;
        end else if (cyc - (t_acc + CNVC) == TO) begin
          exp_timeout = 1'b1;
          in_use      = 1'b0;
        end
      end
      if (trigger) begin
        if (!was_busy) begin
          in_use  = 1'b1;
          t_acc   = cyc;
          t_read  = -1;
          t_valid = -1;
        end else if (exp_ovr < 65535) begin
          exp_ovr++;
        end
      end
    end
    k          = cyc - t_read;
    exp_cnv    = in_use && (cyc < t_acc + CNVC);
    exp_sck    = in_use && t_read >= 0 && k < READ_LEN && ((k / SH) % 2 == 1);
    exp_tvalid = in_use && t_valid >= 0 && cyc >= t_valid;
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge aclk) begin
    if (!aresetn) begin
      checkOutput("rst_cnv", 32'(cnv), 32'(0));
      checkOutput("rst_sck", 32'(sck), 32'(0));
      checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'(0));
      checkOutput("rst_tdata", m_axis_tdata, 32'h0);
      checkOutput("rst_timeout", 32'(timeout), 32'(0));
    end else begin
      checkOutput("cnv", 32'(cnv), 32'(exp_cnv));
      checkOutput("sck", 32'(sck), 32'(exp_sck));
      checkOutput("tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid));
      checkOutput("timeout", 32'(timeout), 32'(exp_timeout));
      if (exp_tvalid) checkOutput("tdata", m_axis_tdata, sext(exp_word));
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
      checkOutput("overrun_count", 32'(overrun_count), 32'(exp_ovr));
`endif
    end
  end

  task automatic applyStimulus();
    @(posedge aclk);
    #1 trigger = 1'b1;
    @(posedge aclk);
    #1 trigger = 1'b0;
  endtask

  task automatic waitValid(input int max_cyc, output int cnv_hi, output int sck_pulses);
    logic sck_prev;
    sck_prev   = 1'b0;
    cnv_hi     = 0;
    sck_pulses = 0;
    for (int i = 0; i < max_cyc; i++) begin
      if (m_axis_tvalid) break;
      @(negedge aclk);
      if (cnv) cnv_hi++;
      if (sck && !sck_prev) sck_pulses++;
      sck_prev = sck;
    end
    checkOutput("tvalid_within_bound", 32'(m_axis_tvalid), 32'(1));
  endtask

  task automatic handshake();
    @(posedge aclk);
    #1 m_axis_tready = 1'b1;
    @(posedge aclk);
    #1 m_axis_tready = 1'b0;
    @(negedge aclk);
    checkOutput("tvalid_after_handshake", 32'(m_axis_tvalid), 32'(0));
  endtask

  task automatic doSample(input logic [DW-1:0] word, input logic [31:0] lit, input string name);
    int c, s;
    adc_word = word;
    applyStimulus();
    waitValid(300, c, s);
    checkOutput(name, m_axis_tdata, lit);
    handshake();
  endtask

  logic [DW-1:0] tp_words [10] = '{18'h00001, 18'h1FFFF, 18'h20001, 18'h15555, 18'h2AAAA,
                                   18'h00000, 18'h3F00F, 18'h12345, 18'h3CDEF, 18'h0FFFF};
  logic [31:0]   tp_lits  [10] = '{32'h00000001, 32'h0001FFFF, 32'hFFFE0001, 32'h00015555, 32'hFFFEAAAA,
                                   32'h00000000, 32'hFFFFF00F, 32'h00012345, 32'hFFFFCDEF, 32'h0000FFFF};

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c, s, n, cnv_seen, pulses, hs0;
    logic prev;

    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("post_reset_tdata", m_axis_tdata, 32'h0);
    checkOutput("post_reset_tvalid", 32'(m_axis_tvalid), 32'(0));
    checkOutput("post_reset_timeout", 32'(timeout), 32'(0));

    // Positive sample with backpressure before the handshake.
    adc_word = 18'h0A5C3;
    applyStimulus();
    waitValid(300, c, s);
    checkOutput("pos_cnv_width", 32'(c), 32'(4));
    checkOutput("pos_sck_pulses", 32'(s), 32'(18));
    checkOutput("pos_tdata", m_axis_tdata, 32'h0000A5C3);
    repeat (20) @(negedge aclk);
    checkOutput("pos_tvalid_held", 32'(m_axis_tvalid), 32'(1));
    checkOutput("pos_tdata_held", m_axis_tdata, 32'h0000A5C3);
    handshake();

    doSample(18'h3FFFF, 32'hFFFFFFFF, "sext_all_ones");
    doSample(18'h20000, 32'hFFFE0000, "sext_min");

    // Backpressure with three dropped triggers.
    adc_word = 18'h0BEEF;
    applyStimulus();
    waitValid(300, c, s);
    cnv_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk);
      #1 trigger = (i == 20 || i == 80 || i == 150);
      if (cnv) cnv_seen++;
    end
    trigger = 1'b0;
    @(negedge aclk);
    checkOutput("bp_no_cnv", 32'(cnv_seen), 32'(0));
    checkOutput("bp_tvalid", 32'(m_axis_tvalid), 32'(1));
    checkOutput("bp_tdata", m_axis_tdata, 32'h0000BEEF);
`ifdef ADC_SPI_READER_OVERRUN_CNT_EN
    checkOutput("bp_overrun", 32'(overrun_count), 32'(3));
`endif
    handshake();

    // BUSY stuck high.
    busy_stuck = 1'b1;
    applyStimulus();
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge aclk);
      if (timeout) break;
      n++;
    end
    checkOutput("to_latency", 32'(n), 32'(CNVC + TO));
    checkOutput("to_flag", 32'(timeout), 32'(1));
    checkOutput("to_no_tvalid", 32'(m_axis_tvalid), 32'(0));
    busy_left  = 1;
    busy_stuck = 1'b0;
    repeat (5) @(posedge aclk);
    doSample(18'h00123, 32'h00000123, "to_next_sample");
    checkOutput("to_sticky", 32'(timeout), 32'(1));

    // Reset in the middle of READ.
    adc_word = 18'h2F0F0;
    applyStimulus();
    pulses = 0;
    prev   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pulses >= 5) break;
      @(posedge aclk);
      #1;
      if (sck && !prev) pulses++;
      prev = sck;
    end
    checkOutput("rr_pulses_before_reset", 32'(pulses), 32'(5));
    #2 aresetn = 1'b0;
    #1;
    checkOutput("rr_sck_async", 32'(sck), 32'(0));
    checkOutput("rr_cnv_async", 32'(cnv), 32'(0));
    checkOutput("rr_tvalid_async", 32'(m_axis_tvalid), 32'(0));
    checkOutput("rr_timeout_async", 32'(timeout), 32'(0));
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    repeat (3) @(posedge aclk);
    doSample(18'h2F0F0, 32'hFFFEF0F0, "rr_next_sample");

    // Throughput: one trigger roughly every 120 cycles with tready held high.
    m_axis_tready = 1'b1;
    hs0 = hs_count;
    for (int i = 0; i < 10; i++) begin
      adc_word = tp_words[i];
      applyStimulus();
      waitValid(200, c, s);
      checkOutput("tp_tdata", m_axis_tdata, tp_lits[i]);
      repeat (120 - 2 - 86) @(posedge aclk);
    end
    @(negedge aclk);
    checkOutput("tp_sample_count", 32'(hs_count - hs0), 32'(10));
    m_axis_tready = 1'b0;
    repeat (5) @(posedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
